// File: rtl/stage_1_fetch.sv
// stage_1_fetch: instruction-fetch stage of the single-cycle CPU.
// Owns the PC, fetches one word over a req/ready handshake into IR, exposes
// the decoded field slices to decode, and picks the next PC from the
// decode-stage branch/jr results when the instruction leaves EXEC.
// A three-state FSM (IDLE -> REQ -> EXEC -> REQ ...) keeps exactly one
// instruction visible to the datapath at a time.
module stage_1_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  // instruction memory handshake
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  // decode-stage feedback, sampled only on the EXEC exit edge
  input  logic        branch,
  input  logic        zero,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic [31:0] expand_imm,
  input  logic        stall,
  // instruction fields, continuous slices of IR
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [5:0]  func,
  // PC view and status
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic        instr_valid,
  output logic [31:0] retired_count
);

  localparam logic [5:0] OP_J = 6'b000010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ret_q, ret_d;

  logic [31:0] seq_pc;
  logic [31:0] j_pc;
  logic [31:0] br_pc;
  logic [31:0] jr_pc;
  logic [31:0] next_pc;
  logic        is_j;
  logic        accept;
  logic        retire;

  // Next-PC candidates; all address arithmetic wraps modulo 2^32.
  always_comb begin
    seq_pc  = pc_q + 32'd4;
    is_j    = (ir_q[31:26] == OP_J);
    j_pc    = {seq_pc[31:28], ir_q[25:0], 2'b00};
    br_pc   = seq_pc + {expand_imm[29:0], 2'b00};
    jr_pc   = {jr_target[31:2], 2'b00};
    // jr wins over j, j over a taken branch, and sequential is the fallback
    next_pc = seq_pc;
    if (jr)                 next_pc = jr_pc;
    else if (is_j)          next_pc = j_pc;
    else if (branch && zero) next_pc = br_pc;
  end

  // FSM next state plus the register update enables derived from it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    accept  = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        // imem_ready only matters here; any other state ignores it
        if (imem_ready) begin
          accept  = 1'b1;
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // a stalled instruction keeps pc, IR and the counter frozen
        if (!stall) begin
          retire  = 1'b1;
          pc_d    = next_pc;
          ret_d   = ret_q + 32'd1;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC, IR and retire counter; async reset lands in IDLE with a nop IR.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      ir_q    <= 32'd0;
      ret_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
    end
  end

  // Outputs decode straight from registered state so that reset drops the
  // request in the same instant it is asserted.
  always_comb begin
    imem_req      = (state_q == S_REQ);
    imem_addr     = pc_q;
    instr_valid   = (state_q == S_EXEC);
    pc            = pc_q;
    pc_plus_4     = seq_pc;
    retired_count = ret_q;
    op            = ir_q[31:26];
    rs            = ir_q[25:21];
    rt            = ir_q[20:16];
    rd            = ir_q[15:11];
    imm           = ir_q[15:0];
    func          = ir_q[5:0];
  end

endmodule
